// File: rtl/cfg_frame_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : cfg_frame_receiver
//  Description : Assembles a SYNC-framed, checksummed configuration word of
//                NUM_BYTES bytes from a UART byte stream. The word is committed
//                to registered outputs only on a valid frame, then held in a
//                fixed-length update window for the downstream heart model.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_frame_receiver #(
   parameter int unsigned NUM_BYTES      = 4,
   parameter logic [31:0] DEFAULT_CFG    = 32'h0032_8384,
   parameter logic [31:0] PULSE_MASK     = 32'hC000_0000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned HOLD_CYCLES    = 33334,
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic [8*NUM_BYTES-1:0] cfg,
   output logic                   cfg_update,
   output logic                   err_csum,
   output logic                   err_timeout,
   output logic [7:0]             frame_cnt,
   output logic                   busy
);

   localparam int unsigned CFG_W  = 8 * NUM_BYTES;
   localparam int unsigned IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   // Configuration constants resized to the payload width (truncate or zero-extend)
   localparam logic [CFG_W-1:0]  DEF_CFG   = CFG_W'(DEFAULT_CFG);
   localparam logic [CFG_W-1:0]  MASK      = CFG_W'(PULSE_MASK);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BYTES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_SYNC = 3'd0;
   localparam logic [2:0] S_PAY  = 3'd1;
   localparam logic [2:0] S_CSUM = 3'd2;
   localparam logic [2:0] S_EVAL = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   logic [2:0]       state_q,       state_d;
   logic [IDX_W-1:0] idx_q,         idx_d;
   logic [7:0]       sum_q,         sum_d;
   logic [IDLE_W-1:0] idle_q,       idle_d;
   logic [HOLD_W-1:0] hold_q,       hold_d;
   logic [CFG_W-1:0] shadow_q,      shadow_d;
   logic [CFG_W-1:0] cfg_q,         cfg_d;
   logic             cfg_update_q,  cfg_update_d;
   logic             err_csum_q,    err_csum_d;
   logic             err_timeout_q, err_timeout_d;
   logic [7:0]       frame_cnt_q,   frame_cnt_d;
   logic             busy_q,        busy_d;

   // Inter-byte gap has reached its limit on this clock (no byte arriving now)
   logic idle_expired;
   assign idle_expired = (idle_q == IDLE_LAST) && !rx_valid;

   // State and datapath registers; every output is registered for the VHM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_SYNC;
         idx_q         <= '0;
         sum_q         <= '0;
         idle_q        <= '0;
         hold_q        <= '0;
         shadow_q      <= DEF_CFG;
         cfg_q         <= DEF_CFG & ~MASK;
         cfg_update_q  <= 1'b0;
         err_csum_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         frame_cnt_q   <= 8'd0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         sum_q         <= sum_d;
         idle_q        <= idle_d;
         hold_q        <= hold_d;
         shadow_q      <= shadow_d;
         cfg_q         <= cfg_d;
         cfg_update_q  <= cfg_update_d;
         err_csum_q    <= err_csum_d;
         err_timeout_q <= err_timeout_d;
         frame_cnt_q   <= frame_cnt_d;
         busy_q        <= busy_d;
      end
   end

   // Next-state selection for the frame parser
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_SYNC: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) state_d = S_PAY;
         end
         S_PAY: begin
            // A SYNC_BYTE value here is ordinary payload; no mid-frame resync
            if (rx_valid) begin
               if (idx_q == LAST_IDX) state_d = S_CSUM;
            end else if (idle_expired) begin
               state_d = S_SYNC;
            end
         end
         S_CSUM: begin
            if (rx_valid)          state_d = S_EVAL;
            else if (idle_expired) state_d = S_SYNC;
         end
         S_EVAL: begin
            state_d = (sum_q == 8'd0) ? S_HOLD : S_SYNC;
         end
         S_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = S_SYNC;
         end
         default: state_d = S_SYNC;
      endcase
   end

   // Datapath updates and registered-output next values per state
   always_comb begin
      idx_d         = idx_q;
      sum_d         = sum_q;
      idle_d        = idle_q;
      hold_d        = hold_q;
      shadow_d      = shadow_q;
      cfg_d         = cfg_q;
      cfg_update_d  = cfg_update_q;
      err_csum_d    = 1'b0;
      err_timeout_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      busy_d        = (state_d != S_SYNC);
      case (state_q)
         S_SYNC: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               idx_d  = '0;
               sum_d  = 8'd0;
               idle_d = '0;
            end
         end
         S_PAY: begin
            if (rx_valid) begin
               for (int i = 0; i < int'(NUM_BYTES); i++) begin
                  if (idx_q == IDX_W'(i)) shadow_d[8*i +: 8] = rx_data;
               end
               sum_d  = sum_q + rx_data;
               idx_d  = idx_q + IDX_W'(1);
               idle_d = '0;
            end else if (idle_expired) begin
               err_timeout_d = 1'b1;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         S_CSUM: begin
            if (rx_valid) begin
               sum_d  = sum_q + rx_data;
               idle_d = '0;
            end else if (idle_expired) begin
               err_timeout_d = 1'b1;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         S_EVAL: begin
            if (sum_q == 8'd0) begin
               cfg_d        = shadow_q;
               cfg_update_d = 1'b1;
               hold_d       = '0;
               frame_cnt_d  = frame_cnt_q + 8'd1;
            end else begin
               err_csum_d = 1'b1;
            end
         end
         S_HOLD: begin
            // Pulse-type bits exist only inside the update window
            if (hold_q == HOLD_LAST) begin
               cfg_update_d = 1'b0;
               cfg_d        = cfg_q & ~MASK;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign cfg         = cfg_q;
   assign cfg_update  = cfg_update_q;
   assign err_csum    = err_csum_q;
   assign err_timeout = err_timeout_q;
   assign frame_cnt   = frame_cnt_q;
   assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_frame_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cfg_frame_receiver
//  Description : Directed bench for cfg_frame_receiver with a commit
//                scoreboard. Short hold/timeout values keep the run brief.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_frame_receiver;

   localparam int          HOLD    = 20;
   localparam int          TMO     = 50;
   localparam logic [31:0] DEF     = 32'h0032_8384;
   localparam logic [31:0] PMASK   = 32'hC000_0000;

   typedef struct packed {
      logic [31:0] cfg;
      logic [7:0]  cnt;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [31:0] cfg;
   logic        cfg_update;
   logic        err_csum;
   logic        err_timeout;
   logic [7:0]  frame_cnt;
   logic        busy;

   int          checks;
   int          errors;
   exp_t        sb[$];
   logic [7:0]  exp_cnt;

   cfg_frame_receiver #(
      .NUM_BYTES      (4),
      .DEFAULT_CFG    (DEF),
      .PULSE_MASK     (PMASK),
      .SYNC_BYTE      (8'hA5),
      .HOLD_CYCLES    (HOLD),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .cfg         (cfg),
      .cfg_update  (cfg_update),
      .err_csum    (err_csum),
      .err_timeout (err_timeout),
      .frame_cnt   (frame_cnt),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; drives one strobed byte and returns at the next negedge
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] pl, input bit good, input bit push);
      logic [7:0] s;
      logic [7:0] cs;
      s = 8'd0;
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) begin
         send_byte(pl[8*i +: 8]);
         s = s + pl[8*i +: 8];
      end
      cs = 8'd0 - s;
      if (!good) cs = cs + 8'd1;
      send_byte(cs);
      if (good && push) begin
         exp_cnt = exp_cnt + 8'd1;
         sb.push_back('{cfg: pl, cnt: exp_cnt});
      end
   endtask

   // Expects a commit one edge after the checksum byte, then checks the window
   task automatic wait_commit(input bit inject);
      exp_t e;
      int   n;
      n = 0;
      while (!cfg_update && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("commit_latency", n, 1);
      chk("sb_nonempty", (sb.size() > 0), 1);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      chk("commit_update", cfg_update, 1);
      chk("commit_cfg", cfg, e.cfg);
      chk("commit_cnt", frame_cnt, e.cnt);
      n = 0;
      if (inject) begin
         send_frame(32'h0102_0304, 1'b1, 1'b0);
         n = 6;
      end
      while (cfg_update && n < HOLD + 8) begin
         @(negedge clk);
         n++;
      end
      chk("hold_len", n, HOLD);
      chk("post_cfg", cfg, e.cfg & ~PMASK);
      chk("post_busy", busy, 0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      exp_cnt  = 8'd0;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_cfg", cfg, DEF & ~PMASK);
      chk("rst_update", cfg_update, 0);
      chk("rst_cnt", frame_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_errc", err_csum, 0);
      chk("rst_errt", err_timeout, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Bad checksum: single err_csum pulse, nothing committed
      send_frame(32'h40C8_82BC, 1'b0, 1'b1);
      @(negedge clk);
      chk("csum_pulse", err_csum, 1);
      chk("csum_no_update", cfg_update, 0);
      @(negedge clk);
      chk("csum_pulse_end", err_csum, 0);
      chk("csum_cfg", cfg, 32'h0032_8384);
      chk("csum_cnt", frame_cnt, 0);
      chk("csum_busy", busy, 0);

      // Reference good frame A5 BC 82 C8 40 BA
      send_frame(32'h40C8_82BC, 1'b1, 1'b1);
      wait_commit(1'b0);

      // Inter-byte timeout after a partial frame
      begin
         int n;
         send_byte(8'hA5);
         chk("to_busy", busy, 1);
         send_byte(8'hBC);
         send_byte(8'h82);
         n = 0;
         while (!err_timeout && n < TMO + 20) begin
            @(negedge clk);
            n++;
         end
         chk("to_delay", n, TMO);
         chk("to_busy_drop", busy, 0);
         @(negedge clk);
         chk("to_pulse_end", err_timeout, 0);
         chk("to_cfg", cfg, 32'h00C8_82BC);
         chk("to_cnt", frame_cnt, exp_cnt);
      end

      // Recovery frame with SYNC_BYTE values in the payload and pulse bit 31 set
      send_frame(32'h80A5_A512, 1'b1, 1'b1);
      wait_commit(1'b0);

      // Leading garbage ignored; a frame sent during the hold window is dropped
      send_byte(8'h11);
      send_byte(8'h22);
      chk("garbage_busy", busy, 0);
      send_frame(32'h40C8_82BC, 1'b1, 1'b1);
      wait_commit(1'b1);
      repeat (5) @(negedge clk);
      chk("drop_update", cfg_update, 0);
      chk("drop_cnt", frame_cnt, exp_cnt);
      chk("drop_cfg", cfg, 32'h00C8_82BC);
      chk("drop_busy", busy, 0);

      // Asynchronous reset in the middle of a hold window
      begin
         int n;
         exp_t e;
         send_frame(32'hC123_4567, 1'b1, 1'b1);
         n = 0;
         while (!cfg_update && n < 8) begin
            @(negedge clk);
            n++;
         end
         e = (sb.size() > 0) ? sb.pop_front() : '0;
         chk("mid_commit_cfg", cfg, e.cfg);
         repeat (5) @(negedge clk);
         rst_n = 1'b0;
         #1;
         chk("arst_cfg", cfg, DEF & ~PMASK);
         chk("arst_update", cfg_update, 0);
         chk("arst_cnt", frame_cnt, 0);
         chk("arst_busy", busy, 0);
         @(negedge clk);
         rst_n   = 1'b1;
         exp_cnt = 8'd0;
         @(negedge clk);
      end

      // 256 committed frames wrap the frame counter back to zero
      for (int f = 0; f < 256; f++) begin
         send_frame($urandom, 1'b1, 1'b1);
         wait_commit(1'b0);
      end
      chk("wrap_cnt", frame_cnt, 0);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cfg_frame_receiver.md
# cfg_frame_receiver

Parametrised successor to the serial mode setter. Consumes the byte stream from `async_receiver` and assembles a framed, checksummed configuration word of `NUM_BYTES` bytes. The word is committed to registered outputs only when the frame is complete and valid, and a stable update window is held for the downstream heart model. Sits between the UART receiver and the VHM parameter inputs. It registers every output, because the VHM does not register its inputs.

## Interface
- `NUM_BYTES`, 4: payload bytes per frame; `cfg` width is `8*NUM_BYTES`.
- `DEFAULT_CFG`, 32'h0032_8384: reset/default configuration (SA_rest=900, pace_en=1, AV_forw=50).
- `PULSE_MASK`, 32'hC000_0000: `cfg` bits that are asserted only during the update window (PACen, PVCen).
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `HOLD_CYCLES`, 33334: update-window length in clocks; must be ≥1.
- `TIMEOUT_CYCLES`, 500000: maximum idle clocks between bytes inside a frame; must be ≥1.
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `rx_data`  in  8  byte from `async_receiver`.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`.
- `cfg`  out  8*NUM_BYTES  committed configuration, little-endian byte order.
- `cfg_update`  out  1  high for exactly `HOLD_CYCLES` clocks after each commit.
- `err_csum`  out  1  one-cycle pulse on a checksum failure.
- `err_timeout`  out  1  one-cycle pulse on an inter-byte timeout.
- `frame_cnt`  out  8  count of committed frames; wraps 255→0.
- `busy`  out  1  high in every state except S_SYNC.

## Operation
- Frame format: `SYNC_BYTE`, then payload bytes b0..b(N-1), then checksum C.
  - The frame is valid when (b0+…+b(N-1)+C) mod 256 == 0.
  - Byte bi loads shadow bits [8i+7:8i].
- States:
  - S_SYNC: `rx_valid` with `rx_data==SYNC_BYTE` → S_PAY, clearing the byte index, running sum and idle counter. Any other byte is ignored.
  - S_PAY: on each `rx_valid`, store the byte into shadow at the byte index, add it to the running sum (8-bit wrap), increment the index, and clear the idle counter. After byte N-1 → S_CSUM.
  - S_CSUM: on `rx_valid`, add the byte to the running sum → S_EVAL.
  - S_EVAL: single cycle, `rx_valid` ignored.
    - Sum==0: `cfg`←shadow, `cfg_update`←1, hold counter←0, `frame_cnt`+1 → S_HOLD.
    - Otherwise: `err_csum`←1 for one cycle → S_SYNC, with `cfg` unchanged.
  - S_HOLD: the hold counter increments every clock and `rx_valid` is ignored. When the counter reaches `HOLD_CYCLES-1`, `cfg_update`←0, `cfg` bits under `PULSE_MASK`←0, → S_SYNC.
- Timeout: in S_PAY or S_CSUM, an idle counter counts clocks without `rx_valid`. When it reaches `TIMEOUT_CYCLES`, `err_timeout` pulses and the state goes to S_SYNC. Shadow is discarded and `cfg` is unchanged.
- In S_PAY, a byte equal to `SYNC_BYTE` is treated as data; there is no resync mid-frame.
- `cfg` bits outside `PULSE_MASK` persist until the next commit. Masked bits are 1 only inside the update window, and only if set in the committed frame.
- Counter widths are sized by $clog2 of their parameter. The hold and idle counters saturate and never wrap.

## Timing
- Reset (async assert, sync-safe deassert):
  - State S_SYNC.
  - `cfg`=`DEFAULT_CFG & ~PULSE_MASK` (truncated or zero-extended to 8*NUM_BYTES).
  - `cfg_update`=0, `err_csum`=0, `err_timeout`=0, `frame_cnt`=0, `busy`=0.
  - Shadow=`DEFAULT_CFG`.
- Latency: checksum byte strobed at edge k → S_EVAL after k. New `cfg` and `cfg_update`=1 are visible after edge k+1. `cfg_update` falls after edge k+1+`HOLD_CYCLES`.
- `err_csum` is high for the cycle after edge k+1; `err_timeout` is high for one cycle.
- Reset mid-frame or mid-hold returns every output to its reset value immediately. The partial frame is lost.
- Bytes arriving in S_EVAL or S_HOLD are dropped and no error is raised.

## Test plan
- Reset → `cfg`=0x0032_8384, `cfg_update`=0, `frame_cnt`=0, `busy`=0.
- Frame A5 BC 82 C8 40 BA:
  - `cfg`=0x40C8_82BC for exactly 33334 cycles with `cfg_update`=1 and `frame_cnt`=1.
  - `cfg` then reads 0x00C8_82BC and `cfg_update`=0.
- Frame A5 BC 82 C8 40 BB → one-cycle `err_csum`; `cfg` remains 0x0032_8384 and `frame_cnt` remains 0.
- A5 BC 82, then 500000 idle clocks:
  - `err_timeout` pulses once and `busy` drops.
  - A following valid frame commits normally.
- Garbage 11 22 A5 BC 82 C8 40 BA → the leading bytes are ignored and the frame commits. A second frame sent during S_HOLD is dropped, with no commit and `frame_cnt`=1.
- `rst_n` asserted mid-hold → outputs return to reset values on the next sample, with no clock edge needed. Also exercise 256 valid frames → `frame_cnt` wraps to 0.
